// File: rtl/pb_io_bank_if.sv
// pb_io_bank_if: pacoblaze3 port bus between processor (master) and I/O bank (slave).
interface pb_io_bank_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;
   modport master (
      output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
      input  in_port, interrupt
   );
   modport slave (
      input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
      output in_port, interrupt
   );
endinterface

// File: rtl/pb_io_bank.sv
// pb_io_bank: decoded I/O ports, tick timer, ext_irq and maskable pending/ack interrupts for pacoblaze3.
// Define PB_IO_OUT_READBACK_EN to make output ports 0x80+n readable.
module pb_io_bank #(
   parameter int CLK_FREQ_HZ = 25000000,
   parameter int TICK_HZ     = 1,
   parameter int NUM_OUT     = 4,
   parameter int NUM_IN      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   pb_io_bank_if.slave           bus,
   input  logic [NUM_IN*8-1:0]   in_data,
   output logic [NUM_OUT*8-1:0]  out_data,
   input  logic                  ext_irq
);
   localparam int PERIOD = CLK_FREQ_HZ / TICK_HZ;
   localparam int CW = $clog2(PERIOD);
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
   logic [CW-1:0] cnt;
   logic [2:0]    st;
   logic [1:0]    mask;
   logic          ctrl;
   logic [2:0]    sync;
   logic [7:0]    rd;
   logic [2:0]    clr;
   logic          tick, rise, wr_st, wr_mask, wr_ctrl;
   logic          unused_rd;
   assign unused_rd = bus.read_strobe;
   assign tick    = ctrl && cnt == LAST;
   assign rise    = sync[1] & ~sync[2];
   assign wr_st   = bus.write_strobe && bus.port_id == 8'hE0;
   assign wr_mask = bus.write_strobe && bus.port_id == 8'hE1;
   assign wr_ctrl = bus.write_strobe && bus.port_id == 8'hE2;
   assign clr     = wr_st ? bus.out_port[2:0] : 3'b000;
   always_comb begin
      rd = bus.port_id == 8'hE0 ? {5'b0, st} :
           bus.port_id == 8'hE1 ? {6'b0, mask} :
           bus.port_id == 8'hE2 ? {7'b0, ctrl} : 8'h00;
      for (int i = 0; i < NUM_IN; i++)
         if (bus.port_id == 8'(i)) rd = in_data[i*8 +: 8];
`ifdef PB_IO_OUT_READBACK_EN
      for (int i = 0; i < NUM_OUT; i++)
         if (bus.port_id == 8'(128 + i)) rd = out_data[i*8 +: 8];
`else
`endif
   end
   // set events take priority over write-1-to-clear on the same bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt           <= '0;
         st            <= '0;
         mask          <= '0;
         ctrl          <= 1'b1;
         sync          <= '0;
         out_data      <= '0;
         bus.in_port   <= '0;
         bus.interrupt <= 1'b0;
      end else begin
         cnt  <= (!ctrl || tick) ? '0 : cnt + 1'b1;
         sync <= {sync[1:0], ext_irq};
         st   <= {(tick & st[0]) | (st[2] & ~clr[2]),
                  rise | (st[1] & ~clr[1]),
                  tick | (st[0] & ~clr[0])};
         if (wr_mask) mask <= bus.out_port[1:0];
         if (wr_ctrl) ctrl <= bus.out_port[0];
         for (int i = 0; i < NUM_OUT; i++)
            if (bus.write_strobe && bus.port_id == 8'(128 + i)) out_data[i*8 +: 8] <= bus.out_port;
         bus.in_port   <= rd;
         bus.interrupt <= bus.interrupt_ack ? 1'b0 : |(st[1:0] & mask);
      end
   end
endmodule

// File: doc/pb_io_bank.md
# pb_io_bank

Parametrised I/O port bank and interrupt controller for the pacoblaze3 soft processor. Sits between the processor bus (port_id/out_port/in_port/strobes) and board-level logic. Provides fully decoded 8-bit output and input ports, a periodic tick timer, an external interrupt input and a maskable pending/acknowledge interrupt scheme. Replaces hand-wired one-hot port decoding and fixed 1 Hz interrupt logic in processor top levels.

## Interface
- CLK_FREQ_HZ, 25000000: system clock frequency.
- TICK_HZ, 1: timer tick rate; PERIOD = CLK_FREQ_HZ/TICK_HZ, must be ≥ 2.
- NUM_OUT, 4: number of output ports, 1..8.
- NUM_IN, 2: number of input ports, 1..8.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  reset; asynchronous, active-high.
- port_id  input  8  processor port address.
- out_port  input  8  processor write data.
- write_strobe  input  1  processor write qualifier.
- read_strobe  input  1  processor read qualifier (unused for side effects).
- in_port  output  8  registered read data to processor.
- interrupt  output  1  interrupt request to processor.
- interrupt_ack  input  1  processor interrupt acknowledge.
- in_data  input  NUM_IN*8  input port n at bits [8n+7:8n].
- out_data  output  NUM_OUT*8  output port n at bits [8n+7:8n].
- ext_irq  input  1  asynchronous external interrupt request, rising-edge sensitive.

## Operation
- Address map (full 8-bit decode): 0x00+n input port n (n<NUM_IN); 0x80+n output port n (n<NUM_OUT); 0xE0 STATUS; 0xE1 MASK; 0xE2 CTRL.
- Output port write: write_strobe with port_id=0x80+n loads out_port into out_data port n. Writes to unmapped addresses ignored.
- STATUS bits: [0] timer pending, [1] ext_irq pending, [2] timer overrun (sticky, not an interrupt source), [7:3] read 0. Write-1-to-clear per bit.
- MASK: r/w, bits [1:0] enable interrupt sources; [7:2] read 0.
- CTRL: bit0 timer enable; [7:1] read 0.
- Timer: counter 0..PERIOD-1, width $clog2(PERIOD). On edge with counter=PERIOD-1 and enable=1: counter→0, STATUS[0] set; if STATUS[0] already set, STATUS[2] also set. Enable=0: counter held at 0; re-enable yields a full period before first tick.
- ext_irq: 2-flop synchroniser then rising-edge detect; edge sets STATUS[1].
- Simultaneous set event and write-1-to-clear on the same bit: set wins.
- interrupt register: each edge, if interrupt_ack → 0, else → |(STATUS[1:0] & MASK[1:0]). Level-style: reasserts the cycle after ack if the handler has not cleared the pending bit.
- Read mux: in_port registered from port_id each edge regardless of read_strobe; unmapped addresses return 0x00. Reads never alter state.

## Timing
- Reset values: out_data all 0x00, in_port 0x00, interrupt 0, STATUS 0x00, MASK 0x00, CTRL 0x01 (timer running), timer counter 0, synchroniser flops 0.
- Write latency: register/out_data updated on the edge where write_strobe is sampled high.
- Read latency: in_port valid one edge after port_id is presented.
- ext_irq rise → STATUS[1] set at 3rd following edge → interrupt at 4th (if masked in).
- Timer tick edge sets STATUS[0]; interrupt asserts on next edge.
- Reset mid-operation: all state returns to reset values immediately; pending events discarded.

## Configuration
- PB_IO_OUT_READBACK_EN defined: reads of 0x80+n (n<NUM_OUT) return current out_data port n.
- Undefined: reads of 0x80+n return 0x00; no readback mux is built.

## Test plan
- Reset then read 0xE2, 0xE0, 0xE1 -> in_port 0x01, 0x00, 0x00 one edge after each address; all out_data 0x00, interrupt 0.
- NUM_OUT=4: write 0x5A to 0x82, 0xFF to 0x84 -> out_data port 2 = 0x5A next edge, no other port changes; readback 0x82 returns 0x5A with PB_IO_OUT_READBACK_EN, 0x00 without.
- CLK_FREQ_HZ=100, TICK_HZ=10, MASK=0x01 -> STATUS[0] sets every 10 cycles, interrupt next edge; pulse interrupt_ack without clearing -> interrupt drops one cycle then reasserts; write 0x01 to 0xE0 -> deasserts.
- Same timer, MASK=0x00, no clear for 25 cycles -> STATUS reads 0x05, interrupt stays 0.
- Raise ext_irq, MASK=0x02 -> STATUS[1] at 3rd edge, interrupt at 4th; held-high ext_irq after clear produces no new pending.
- Write 0x02 to 0xE0 on the same edge an ext_irq edge is detected -> STATUS[1] remains 1.
